// File: rtl/router_pkg.sv
// Shared constants and the per-beat check update used by the router input register stage.
package router_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;
  localparam int CHK_XOR    = 0;
  localparam int CHK_CRC    = 1;
  localparam int MAX_W      = 32;

  // One accumulator update: XOR, or a w-bit MSB-first CRC step (init/out handled by caller).
  function automatic logic [MAX_W-1:0] chk_step(
    input logic [MAX_W-1:0] acc,
    input logic [MAX_W-1:0] x,
    input logic [MAX_W-1:0] poly,
    input int               w,
    input int               mode
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] c;
    logic [4:0]       msb;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    msb  = 5'(w - 1);
    c    = (acc ^ x) & mask;
    if (mode == CHK_CRC) begin
      for (int i = 0; i < MAX_W; i++) begin
        if (i < w) begin
          if (c[msb]) c = ((c << 1) ^ poly) & mask;
          else        c = (c << 1) & mask;
        end
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/router_chk_acc.sv
// Packet check accumulator: XOR parity or CRC, cleared on header, updated on enabled beats.
module router_chk_acc
  import router_pkg::*;
#(
  parameter int          DATA_W   = DATA_W_DEF,
  parameter int          CHK_MODE = CHK_XOR,
  parameter logic [31:0] CRC_POLY = 32'h07
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] acc
);

  logic [MAX_W-1:0] nxt;
  logic             unused_hi;

  assign nxt = chk_step(MAX_W'(acc), MAX_W'(data), CRC_POLY, DATA_W, CHK_MODE);

  generate
    if (DATA_W < MAX_W) begin : g_hi
      assign unused_hi = ^nxt[MAX_W-1:DATA_W];
    end else begin : g_full
      assign unused_hi = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= nxt[DATA_W-1:0];
  end

endmodule

// File: rtl/router_reg_chk.sv
// Router input register stage: header latch, FIFO write mux with full-hold replay,
// packet check accumulation/compare and payload length check.
module router_reg_chk
  import router_pkg::*;
#(
  parameter int          DATA_W   = DATA_W_DEF,
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int          LEN_W    = DATA_W - ADDR_W,
  parameter int          CHK_MODE = CHK_XOR,
  parameter logic [31:0] CRC_POLY = 32'h07
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic              fifo_full,
  input  logic              rst_int_reg,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic              len_err
);

  logic [DATA_W-1:0] hdr;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] chk;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_x;
  logic [LEN_W:0]    beat_cnt;
  logic [LEN_W-1:0]  hdr_len;
  logic              pd_d;

  logic hdr_cap, lfd_go, ld_go, laf_go;
  logic acc_en, beat_inc, chk_cap, cmp_go;

  // A header decode overrides any load the FSM asserts in the same cycle.
  assign hdr_cap  = detect_add & pkt_valid;
  assign lfd_go   = lfd_state & ~detect_add;
  assign ld_go    = ld_state  & ~detect_add;
  assign laf_go   = laf_state & ~detect_add;

  assign hdr_len  = hdr[DATA_W-1:ADDR_W];
  assign beat_inc = (ld_go & pkt_valid & ~fifo_full) | laf_go;
  assign chk_cap  = (ld_go & ~fifo_full & ~pkt_valid)
                  | (laf_go & low_pkt_valid & ~parity_done);
  assign cmp_go   = parity_done & ~pd_d;
  assign acc_en   = lfd_go | (ld_go & pkt_valid & ~full_state) | (laf_go & pkt_valid);

  always_comb begin
    acc_x = data_in;
    if (lfd_go)      acc_x = hdr;
    else if (laf_go) acc_x = hold;
  end

  router_chk_acc #(
    .DATA_W   (DATA_W),
    .CHK_MODE (CHK_MODE),
    .CRC_POLY (CRC_POLY)
  ) u_chk_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (hdr_cap),
    .en   (acc_en),
    .data (acc_x),
    .acc  (acc)
  );

  // FIFO write data and the byte held while the FIFO is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      hold <= '0;
      hdr  <= '0;
    end else if (hdr_cap) begin
      hdr <= data_in;
    end else begin
      if (lfd_go)                  dout <= hdr;
      else if (ld_go & ~fifo_full) dout <= data_in;
      else if (laf_go)             dout <= hold;
      if (ld_go & fifo_full)       hold <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (hdr_cap) begin
      beat_cnt <= '0;
    end else if (beat_inc && (beat_cnt != '1)) begin
      beat_cnt <= beat_cnt + {{LEN_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       low_pkt_valid <= 1'b0;
    else if (ld_go & ~pkt_valid)   low_pkt_valid <= 1'b1;
    else if (rst_int_reg)          low_pkt_valid <= 1'b0;
  end

  // Check byte capture, then compare one cycle after parity_done rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk         <= '0;
      parity_done <= 1'b0;
      pd_d        <= 1'b0;
      err         <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      pd_d <= parity_done;
      if (hdr_cap) begin
        parity_done <= 1'b0;
        err         <= 1'b0;
        len_err     <= 1'b0;
      end else begin
        if (chk_cap) begin
          chk         <= data_in;
          parity_done <= 1'b1;
        end
        if (cmp_go) begin
          err     <= (acc != chk);
          len_err <= (beat_cnt != {1'b0, hdr_len});
        end
      end
    end
  end

endmodule
